nts_api_router: RTL and testbench

- Parametrised successor of the NTS engine register-bus demux.
- Routes one external 32-bit register access to one of NUM_TARGETS internal API endpoints. Each endpoint owns a configurable [base, stop] address window.
- Adds behaviour the fixed-size demux lacks:
  - an explicit transaction FSM
  - configurable read wait states
  - a decode-error response
  - overrun detection when a request arrives while busy.
- Sits between the host bus bridge and the engine, clock, cookie, keymem, debug and parser sub-blocks.

---
 rtl/nts_api_router_pkg.sv | 22 ++
 rtl/nts_api_router_decode.sv | 44 ++++
 rtl/nts_api_router.sv | 172 +++++++++++++++++
 tb/tb_nts_api_router.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nts_api_router_pkg.sv
// Shared types and default address map for the NTS API router.
// Holds the transaction FSM encoding and the six-endpoint default windows.
package nts_api_router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESPOND
    } state_t;

    localparam int WAIT_CNT_WIDTH = 4;
    localparam int DEFAULT_NUM_TARGETS = 6;

    // Target i occupies slice i, so the rightmost entry is target 0.
    localparam logic [71:0] DEFAULT_ADDR_BASE =
        {12'h200, 12'h180, 12'h080, 12'h020, 12'h010, 12'h000};
    localparam logic [71:0] DEFAULT_ADDR_STOP =
        {12'h2FF, 12'h1F0, 12'h17F, 12'h03F, 12'h01F, 12'h009};

endpackage

// File: rtl/nts_api_router_decode.sv
// Combinational address-window decoder for the NTS API router.
// The lowest-index window wins; an offset wider than the local bus is a decode error.
module nts_api_router_decode #(
    parameter int NUM_TARGETS = 6,
    parameter int ADDR_WIDTH = 12,
    parameter int LOCAL_ADDR_WIDTH = 8,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] ADDR_BASE = nts_api_router_pkg::DEFAULT_ADDR_BASE,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] ADDR_STOP = nts_api_router_pkg::DEFAULT_ADDR_STOP
) (
    input  logic [ADDR_WIDTH-1:0]       addr,
    output logic [NUM_TARGETS-1:0]      sel,
    output logic [LOCAL_ADDR_WIDTH-1:0] local_addr,
    output logic                        error
);

    logic                   hit;
    logic [NUM_TARGETS-1:0] found_sel;
    logic [ADDR_WIDTH-1:0]  offset;

    always_comb begin
        hit        = 1'b0;
        found_sel  = '0;
        offset     = '0;
        sel        = '0;
        local_addr = '0;
        error      = 1'b1;
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (addr >= ADDR_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                addr <= ADDR_STOP[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit          = 1'b1;
                found_sel    = '0;
                found_sel[i] = 1'b1;
                offset       = addr - ADDR_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        if (hit && (offset >> LOCAL_ADDR_WIDTH) == '0) begin
            sel        = found_sel;
            local_addr = LOCAL_ADDR_WIDTH'(offset);
            error      = 1'b0;
        end
    end

endmodule

// File: rtl/nts_api_router.sv
// Routes one external register access to one of NUM_TARGETS internal endpoints.
// Define NTS_API_ROUTER_ERRCNT_EN to build the saturating error/overrun counter.
module nts_api_router #(
    parameter int NUM_TARGETS = 6,
    parameter int ADDR_WIDTH = 12,
    parameter int LOCAL_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] ADDR_BASE = nts_api_router_pkg::DEFAULT_ADDR_BASE,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] ADDR_STOP = nts_api_router_pkg::DEFAULT_ADDR_STOP,
    parameter int READ_WAIT = 0,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 32'hDEAD_0000
) (
    input  logic                              i_clk,
    input  logic                              i_areset_n,
    output logic                              o_busy,
    input  logic                              i_external_api_cs,
    input  logic                              i_external_api_we,
    input  logic [ADDR_WIDTH-1:0]             i_external_api_address,
    input  logic [DATA_WIDTH-1:0]             i_external_api_write_data,
    output logic [DATA_WIDTH-1:0]             o_external_api_read_data,
    output logic                              o_external_api_read_data_valid,
    output logic                              o_external_api_error,
    output logic                              o_overrun,
    output logic [15:0]                       o_error_count,
    output logic                              o_internal_api_we,
    output logic [LOCAL_ADDR_WIDTH-1:0]       o_internal_api_address,
    output logic [DATA_WIDTH-1:0]             o_internal_api_write_data,
    output logic [NUM_TARGETS-1:0]            o_internal_api_cs,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] i_internal_api_read_data
);

    import nts_api_router_pkg::*;

    state_t                      state;
    state_t                      next_state;
    logic                        req_we;
    logic [ADDR_WIDTH-1:0]       req_addr;
    logic [DATA_WIDTH-1:0]       req_wdata;
    logic [NUM_TARGETS-1:0]      sel_q;
    logic [LOCAL_ADDR_WIDTH-1:0] local_q;
    logic                        err_q;
    logic [WAIT_CNT_WIDTH-1:0]   wait_cnt;
    logic [DATA_WIDTH-1:0]       access_data;
    logic [DATA_WIDTH-1:0]       read_data_q;
    logic                        overrun_q;
    logic [NUM_TARGETS-1:0]      dec_sel;
    logic [LOCAL_ADDR_WIDTH-1:0] dec_local;
    logic                        dec_err;
    logic [DATA_WIDTH-1:0]       selected;
    logic                        drive;
    logic                        valid;

    nts_api_router_decode #(
        .NUM_TARGETS     (NUM_TARGETS),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .LOCAL_ADDR_WIDTH(LOCAL_ADDR_WIDTH),
        .ADDR_BASE       (ADDR_BASE),
        .ADDR_STOP       (ADDR_STOP)
    ) u_decode (
        .addr      (req_addr),
        .sel       (dec_sel),
        .local_addr(dec_local),
        .error     (dec_err)
    );

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (i_external_api_cs) next_state = ST_DECODE;
            ST_DECODE:  next_state = ST_ACCESS;
            ST_ACCESS:  if (wait_cnt == '0) next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_RESPOND;
            ST_RESPOND: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        selected = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (sel_q[i]) begin
                selected = selected | i_internal_api_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Writes always leave ACCESS after one cycle; only reads pay the wait states.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            sel_q       <= '0;
            local_q     <= '0;
            err_q       <= 1'b0;
            wait_cnt    <= '0;
            access_data <= '0;
            read_data_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= i_external_api_cs && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (i_external_api_cs) begin
                        req_we    <= i_external_api_we;
                        req_addr  <= i_external_api_address;
                        req_wdata <= i_external_api_write_data;
                    end
                end
                ST_DECODE: begin
                    sel_q    <= dec_sel;
                    local_q  <= dec_local;
                    err_q    <= dec_err;
                    wait_cnt <= req_we ? '0 : WAIT_CNT_WIDTH'(READ_WAIT);
                end
                ST_ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        access_data <= err_q ? ERROR_DATA : selected;
                    end
                end
                ST_CAPTURE: read_data_q <= req_we ? '0 : access_data;
                default: ;
            endcase
        end
    end

    assign drive = (state == ST_ACCESS) && !err_q;
    assign valid = (state == ST_RESPOND);

    assign o_busy                         = (state != ST_IDLE);
    assign o_internal_api_cs              = drive ? sel_q : '0;
    assign o_internal_api_we              = drive && req_we;
    assign o_internal_api_address         = drive ? local_q : '0;
    assign o_internal_api_write_data      = drive ? req_wdata : '0;
    assign o_external_api_read_data       = read_data_q;
    assign o_external_api_read_data_valid = valid;
    assign o_external_api_error           = valid && err_q;
    assign o_overrun                      = overrun_q;

`ifdef NTS_API_ROUTER_ERRCNT_EN
    logic [15:0] err_count;
    logic [16:0] cnt_sum;

    // A decode-error response and an overrun pulse can land together; both count.
    always_comb begin
        cnt_sum = {1'b0, err_count} + {16'b0, o_external_api_error} + {16'b0, overrun_q};
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            err_count <= '0;
        end else begin
            err_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    assign o_error_count = err_count;
`else
    assign o_error_count = '0;
`endif

endmodule

// File: tb/tb_nts_api_router.sv
// Self-checking bench for nts_api_router: a READ_WAIT=0 and a READ_WAIT=3 instance
// share one stimulus stream and are compared against a window-table reference model.
module tb_nts_api_router;

    logic        clk;
    logic        rst_n;
    logic        ext_cs;
    logic        ext_we;
    logic [11:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [191:0] rd_bus;

    logic        busy    [2];
    logic [31:0] rdata   [2];
    logic        rvalid  [2];
    logic        rerror  [2];
    logic        overrun [2];
    logic [15:0] errcnt  [2];
    logic        iwe     [2];
    logic [7:0]  iaddr   [2];
    logic [31:0] iwdata  [2];
    logic [5:0]  icsel   [2];

    logic [31:0] ep_data [6];
    logic [11:0] win_base [6] = '{12'h000, 12'h010, 12'h020, 12'h080, 12'h180, 12'h200};
    logic [11:0] win_stop [6] = '{12'h009, 12'h01F, 12'h03F, 12'h17F, 12'h1F0, 12'h2FF};

    int checks;
    int errors;
    int exp_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        nts_api_router #(
            .READ_WAIT(g * 3)
        ) dut (
            .i_clk                         (clk),
            .i_areset_n                    (rst_n),
            .o_busy                        (busy[g]),
            .i_external_api_cs             (ext_cs),
            .i_external_api_we             (ext_we),
            .i_external_api_address        (ext_addr),
            .i_external_api_write_data     (ext_wdata),
            .o_external_api_read_data      (rdata[g]),
            .o_external_api_read_data_valid(rvalid[g]),
            .o_external_api_error          (rerror[g]),
            .o_overrun                     (overrun[g]),
            .o_error_count                 (errcnt[g]),
            .o_internal_api_we             (iwe[g]),
            .o_internal_api_address        (iaddr[g]),
            .o_internal_api_write_data     (iwdata[g]),
            .o_internal_api_cs             (icsel[g]),
            .i_internal_api_read_data      (rd_bus)
        );
    end

    always #5 clk = ~clk;

    always_comb begin
        rd_bus = '0;
        for (int i = 0; i < 6; i++) begin
            rd_bus[i*32 +: 32] = ep_data[i];
        end
    end

    // Returns the owning endpoint, or -1 when the access is a decode error.
    function automatic int model_target(input logic [11:0] a);
        for (int i = 0; i < 6; i++) begin
            if (a >= win_base[i] && a <= win_stop[i]) begin
                return ((a - win_base[i]) < 256) ? i : -1;
            end
        end
        return -1;
    endfunction

    task automatic check_output(input string tag, input int d, input int k,
                                input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d cycle T+%0d: observed %h expected %h", tag, d, k, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_output({tag, "_busy"}, d, 0, busy[d], 0);
            check_output({tag, "_cs"}, d, 0, icsel[d], 0);
            check_output({tag, "_int_we"}, d, 0, iwe[d], 0);
            check_output({tag, "_int_addr"}, d, 0, iaddr[d], 0);
            check_output({tag, "_int_wdata"}, d, 0, iwdata[d], 0);
            check_output({tag, "_valid"}, d, 0, rvalid[d], 0);
            check_output({tag, "_error"}, d, 0, rerror[d], 0);
            check_output({tag, "_rdata"}, d, 0, rdata[d], 0);
            check_output({tag, "_overrun"}, d, 0, overrun[d], 0);
            check_output({tag, "_err_count"}, d, 0, errcnt[d], 0);
        end
    endtask

    // Issues one request and checks both instances cycle by cycle from T+1 to T+9.
    task automatic apply_stimulus(input logic we, input logic [11:0] addr,
                                  input logic [31:0] wdata, input bit probe);
        int tgt;
        int lat;
        logic drv;
        logic vld;
        logic [5:0]  exp_sel;
        logic [7:0]  exp_local;
        logic [31:0] exp_rdata;
        tgt       = model_target(addr);
        exp_sel   = (tgt >= 0) ? 6'(1 << tgt) : 6'b0;
        exp_local = (tgt >= 0) ? 8'(addr - win_base[tgt]) : 8'h00;
        exp_rdata = we ? 32'h0 : ((tgt >= 0) ? ep_data[tgt] : 32'hDEAD_0000);
        ext_cs    = 1'b1;
        ext_we    = we;
        ext_addr  = addr;
        ext_wdata = wdata;
        @(posedge clk); #1;
        ext_cs = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            for (int d = 0; d < 2; d++) begin
                lat = we ? 0 : d * 3;
                drv = (k >= 2) && (k <= 2 + lat) && (tgt >= 0);
                vld = (k == 4 + lat);
                check_output("busy", d, k, busy[d], (k <= 4 + lat));
                check_output("cs", d, k, icsel[d], drv ? exp_sel : 6'b0);
                check_output("int_we", d, k, iwe[d], drv && we);
                check_output("int_addr", d, k, iaddr[d], drv ? exp_local : 8'h00);
                check_output("int_wdata", d, k, iwdata[d], drv ? wdata : 32'h0);
                check_output("valid", d, k, rvalid[d], vld);
                check_output("error", d, k, rerror[d], vld && (tgt < 0));
                check_output("overrun", d, k, overrun[d], probe && (k == 3));
                if (vld) begin
                    check_output("rdata", d, k, rdata[d], exp_rdata);
                end
            end
            if (probe && k == 2) ext_cs = 1'b1;
            if (k == 3) ext_cs = 1'b0;
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
`ifdef NTS_API_ROUTER_ERRCNT_EN
            exp_cnt[d] += ((tgt < 0) ? 1 : 0) + (probe ? 1 : 0);
`endif
            check_output("err_count", d, 9, errcnt[d], 32'(exp_cnt[d]));
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        ext_cs    = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;
        checks    = 0;
        errors    = 0;
        exp_cnt   = '{0, 0};
        for (int i = 0; i < 6; i++) ep_data[i] = 32'h1000_0000 + 32'(i);

        #2;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed transactions");
        ep_data[2] = 32'h1234_5678;
        apply_stimulus(1'b0, 12'h025, 32'h0, 1'b0);
        apply_stimulus(1'b1, 12'h185, 32'hCAFE_F00D, 1'b0);
        apply_stimulus(1'b0, 12'h050, 32'h0, 1'b0);
        ep_data[1] = 32'hA5A5_0101;
        apply_stimulus(1'b0, 12'h010, 32'h0, 1'b0);
        apply_stimulus(1'b0, 12'h025, 32'h0, 1'b1);
        apply_stimulus(1'b0, 12'h009, 32'h0, 1'b0);
        apply_stimulus(1'b0, 12'h00A, 32'h0, 1'b0);
        apply_stimulus(1'b0, 12'h2FF, 32'h0, 1'b0);
        apply_stimulus(1'b1, 12'h300, 32'h1111_2222, 1'b0);
        apply_stimulus(1'b0, 12'h1F0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 12'h1F1, 32'h0, 1'b1);
        apply_stimulus(1'b1, 12'h17F, 32'h3333_4444, 1'b0);

        $display("[TB] reset during a read");
        ep_data[2] = 32'h5555_AAAA;
        ext_cs   = 1'b1;
        ext_we   = 1'b0;
        ext_addr = 12'h025;
        @(posedge clk); #1;
        ext_cs = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = '{0, 0};
        check_idle_outputs("mid_reset");
        @(posedge clk); #1;
        check_idle_outputs("held_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(1'b0, 12'h025, 32'h0, 1'b0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 6; i++) ep_data[i] = $urandom;
            apply_stimulus(1'($urandom_range(0, 1)), 12'($urandom_range(0, 12'h3FF)),
                           $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
